gpio_port_ctrl: RTL and testbench
=================================

Name: gpio_port_ctrl

Overview:
- Parametrised GPIO port controller; successor to the fixed 8-bit porta pad hookup at SoC top.
- Provides per-bit direction, output data, 2-flop input synchronisation, optional debounce, and per-bit edge/level interrupts through a simple single-cycle register interface.
- The SoC top instantiates it and builds tristate pads from o_gpio_out/o_gpio_oe.

Parameters:
GPIO_W, 8, number of GPIO bits (1..32)
DB_DIV, 16, debounce sample-tick period in clock cycles (>=2)

Ports:
i_pad_clk  in  1  system clock
i_pad_rst_b  in  1  asynchronous active-low reset
i_reg_sel  in  1  register access strobe, one cycle per access
i_reg_wr  in  1  1=write, 0=read (qualified by i_reg_sel)
i_reg_addr  in  3  register index
i_reg_wdata  in  GPIO_W  write data
o_reg_rdata  out  GPIO_W  read data, registered
i_gpio_in  in  GPIO_W  raw pad input (asynchronous)
o_gpio_out  out  GPIO_W  pad output data
o_gpio_oe  out  GPIO_W  pad output enable, 1=drive
o_gpio_intr  out  GPIO_W  per-bit interrupt = INTSTAT & INTEN
o_gpio_intr_any  out  1  OR of o_gpio_intr

Behaviour:
- Register map (index: name, access, reset):
  - 0: DR, RW, 0.
  - 1: DDR, RW, 0 (1=output).
  - 2: EXT, RO, filtered input.
  - 3: INTEN, RW, 0.
  - 4: INTTYPE, RW, 0 (1=edge, 0=level).
  - 5: INTPOL, RW, 0 (1=rising/high, 0=falling/low).
  - 6: INTSTAT, W1C, 0.
  - 7: DEBEN, RW, 0.
- Register accesses:
  - Writes to EXT are ignored.
  - Writes take effect at the clock edge where i_reg_sel & i_reg_wr.
- Reads:
  - Read with i_reg_sel & ~i_reg_wr at edge k: o_reg_rdata holds the value after edge k and until the next read.
  - Read latency is 1 cycle.
- Outputs: o_gpio_out = DR, o_gpio_oe = DDR, both combinational from registers.
- Reset values: all outputs and all flops 0, including sync, debounce and prev flops. Reset is asynchronous mid-operation: every register clears immediately, no pending interrupt survives.
- Synchroniser: sync1 <= i_gpio_in, sync2 <= sync1.
- Debounce:
  - Free-running prescaler counts 0..DB_DIV-1; tick when count==DB_DIV-1, then wrap to 0.
  - On tick, per bit, shift sync2 into 2-deep history h1,h0.
  - Per bit, filt <= (DEBEN ? (on tick, if sync2==h1==h0 then sync2, else hold) : sync2).
  - Clearing DEBEN makes filt follow sync2 next cycle. History keeps shifting regardless of DEBEN.
- EXT = filt. prev <= filt every cycle.
- Event per bit:
  - Edge mode: rising = filt & ~prev; falling = ~filt & prev.
  - Level mode: filt==INTPOL.
- INTSTAT update per bit, each cycle:
  - Set if INTEN & event.
  - Otherwise cleared if W1C write with wdata bit 1.
  - Otherwise hold.
  - Set wins over simultaneous W1C clear.
  - Level mode with condition still true re-sets the bit the cycle after clear.
- INTEN, INTTYPE and INTPOL changes do not clear INTSTAT. Clearing INTEN masks o_gpio_intr but keeps the status bit.
- Latency, DEBEN=0: pad change set up before edge k gives:
  - sync2 after edge k+1.
  - filt/EXT after edge k+2.
  - INTSTAT/o_gpio_intr after edge k+3.
- Input bits with DDR=1 are still sampled: EXT reflects the pad, loopback allowed.
- Bits >= GPIO_W in wdata are not present. i_reg_addr fully decoded (8 entries).

Test Plan:
- Reset/regs: release reset, read each of the 8 registers -> all 0. Write DR=0xA5, DDR=0x0F, read back -> o_gpio_out=0xA5, o_gpio_oe=0x0F, rdata 0xA5/0x0F one cycle after read strobe.
- Sync latency: DEBEN=0, drive i_gpio_in=0x01 before edge k -> EXT read issued at edge k+2 returns 0x01. A read at edge k+1 returns 0x00.
- Edge interrupt:
  - INTEN=0x01, INTTYPE=0x01, INTPOL=0x01, pulse bit0 high for 5 cycles -> INTSTAT=0x01, o_gpio_intr_any=1 after edge k+3, single set.
  - W1C 0x01 -> clears.
  - Falling edge does not set.
- Level and collision:
  - INTTYPE=0, INTPOL=0x02, INTEN=0x02, hold bit1 high, W1C 0x02 -> INTSTAT bit1 reads 1 again the following cycle.
  - Edge event coincident with W1C on the same bit -> bit stays 1.
- Debounce:
  - DEBEN=0xFF, DB_DIV=16, glitch bit2 high for 10 cycles -> EXT stays 0.
  - Hold high steadily -> EXT becomes 1 on the third tick after sync2 rises (<=48 cycles + sync latency).
- Async reset mid-operation: with INTSTAT=0x03 and DR=0xFF, assert i_pad_rst_b low between clock edges -> o_gpio_out, o_gpio_oe, o_gpio_intr, o_reg_rdata go 0 immediately without a clock edge.

Source files
------------

// File: rtl/gpio_port_ctrl.sv
// GPIO port controller: per-bit direction/data registers, 2-flop input
// synchroniser, optional tick-sampled debounce and per-bit edge/level
// interrupts behind a single-cycle register interface.
module gpio_port_ctrl #(
  parameter int GPIO_W = 8,
  parameter int DB_DIV = 16
) (
  input  logic              i_pad_clk,
  input  logic              i_pad_rst_b,
  input  logic              i_reg_sel,
  input  logic              i_reg_wr,
  input  logic [2:0]        i_reg_addr,
  input  logic [GPIO_W-1:0] i_reg_wdata,
  output logic [GPIO_W-1:0] o_reg_rdata,
  input  logic [GPIO_W-1:0] i_gpio_in,
  output logic [GPIO_W-1:0] o_gpio_out,
  output logic [GPIO_W-1:0] o_gpio_oe,
  output logic [GPIO_W-1:0] o_gpio_intr,
  output logic              o_gpio_intr_any
);

  localparam int CNT_W = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_DIV - 1);

  localparam logic [2:0] A_DR      = 3'd0;
  localparam logic [2:0] A_DDR     = 3'd1;
  localparam logic [2:0] A_EXT     = 3'd2;
  localparam logic [2:0] A_INTEN   = 3'd3;
  localparam logic [2:0] A_INTTYPE = 3'd4;
  localparam logic [2:0] A_INTPOL  = 3'd5;
  localparam logic [2:0] A_INTSTAT = 3'd6;
  localparam logic [2:0] A_DEBEN   = 3'd7;

  logic [GPIO_W-1:0] dr_q, dr_d, ddr_q, ddr_d;
  logic [GPIO_W-1:0] inten_q, inten_d, inttype_q, inttype_d;
  logic [GPIO_W-1:0] intpol_q, intpol_d, intstat_q, intstat_d;
  logic [GPIO_W-1:0] deben_q, deben_d, rdata_q, rdata_d;
  logic [GPIO_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [GPIO_W-1:0] h1_q, h1_d, h0_q, h0_d;
  logic [GPIO_W-1:0] filt_q, filt_d, prev_q, prev_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              wr_en, rd_en, tick;
  logic [GPIO_W-1:0] stable, rise, fall, edge_ev, lvl_ev, ev, w1c;

  assign wr_en = i_reg_sel & i_reg_wr;
  assign rd_en = i_reg_sel & ~i_reg_wr;

  // Software-writable configuration registers; EXT and INTSTAT are not plain-written here.
  always_comb begin
    dr_d      = dr_q;
    ddr_d     = ddr_q;
    inten_d   = inten_q;
    inttype_d = inttype_q;
    intpol_d  = intpol_q;
    deben_d   = deben_q;
    if (wr_en) begin
      case (i_reg_addr)
        A_DR:      dr_d      = i_reg_wdata;
        A_DDR:     ddr_d     = i_reg_wdata;
        A_INTEN:   inten_d   = i_reg_wdata;
        A_INTTYPE: inttype_d = i_reg_wdata;
        A_INTPOL:  intpol_d  = i_reg_wdata;
        A_DEBEN:   deben_d   = i_reg_wdata;
        default:   ;
      endcase
    end
  end

  // Input path: synchroniser, debounce prescaler, tick-sampled history and filter.
  always_comb begin
    tick    = (cnt_q == CNT_MAX);
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    sync1_d = i_gpio_in;
    sync2_d = sync1_q;
    h1_d    = tick ? sync2_q : h1_q;
    h0_d    = tick ? h1_q : h0_q;
    stable  = ~(sync2_q ^ h1_q) & ~(h1_q ^ h0_q);
    // Debounced bits only move on a tick with three agreeing samples.
    filt_d  = (~deben_q & sync2_q) |
              (deben_q & (tick ? ((stable & sync2_q) | (~stable & filt_q)) : filt_q));
    prev_d  = filt_q;
  end

  // Interrupt status: event sets, W1C clears, set wins a same-cycle collision.
  always_comb begin
    rise      = filt_q & ~prev_q;
    fall      = ~filt_q & prev_q;
    edge_ev   = (intpol_q & rise) | (~intpol_q & fall);
    lvl_ev    = ~(filt_q ^ intpol_q);
    ev        = (inttype_q & edge_ev) | (~inttype_q & lvl_ev);
    w1c       = (wr_en && (i_reg_addr == A_INTSTAT)) ? i_reg_wdata : '0;
    intstat_d = (inten_q & ev) | (intstat_q & ~w1c);
  end

  // Read mux returns the value each register holds after the read edge.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (i_reg_addr)
        A_DR:      rdata_d = dr_d;
        A_DDR:     rdata_d = ddr_d;
        A_EXT:     rdata_d = filt_d;
        A_INTEN:   rdata_d = inten_d;
        A_INTTYPE: rdata_d = inttype_d;
        A_INTPOL:  rdata_d = intpol_d;
        A_INTSTAT: rdata_d = intstat_d;
        default:   rdata_d = deben_d;
      endcase
    end
  end

  // State register bank; asynchronous reset clears everything at once.
  always_ff @(posedge i_pad_clk or negedge i_pad_rst_b) begin
    if (!i_pad_rst_b) begin
      dr_q      <= '0;
      ddr_q     <= '0;
      inten_q   <= '0;
      inttype_q <= '0;
      intpol_q  <= '0;
      intstat_q <= '0;
      deben_q   <= '0;
      rdata_q   <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      h1_q      <= '0;
      h0_q      <= '0;
      filt_q    <= '0;
      prev_q    <= '0;
      cnt_q     <= '0;
    end else begin
      dr_q      <= dr_d;
      ddr_q     <= ddr_d;
      inten_q   <= inten_d;
      inttype_q <= inttype_d;
      intpol_q  <= intpol_d;
      intstat_q <= intstat_d;
      deben_q   <= deben_d;
      rdata_q   <= rdata_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      h1_q      <= h1_d;
      h0_q      <= h0_d;
      filt_q    <= filt_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_reg_rdata     = rdata_q;
  assign o_gpio_out      = dr_q;
  assign o_gpio_oe       = ddr_q;
  assign o_gpio_intr     = intstat_q & inten_q;
  assign o_gpio_intr_any = |o_gpio_intr;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Directed bench for gpio_port_ctrl: register access, sync latency,
// edge/level interrupts, W1C collision, debounce and async reset.
module tb_gpio_port_ctrl;

  logic       clk;
  logic       rst_n;
  logic       sel;
  logic       wr;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic [7:0] gpio_oe;
  logic [7:0] gpio_intr;
  logic       intr_any;

  int errors = 0;
  int checks = 0;

  gpio_port_ctrl #(.GPIO_W(8), .DB_DIV(16)) dut (
    .i_pad_clk       (clk),
    .i_pad_rst_b     (rst_n),
    .i_reg_sel       (sel),
    .i_reg_wr        (wr),
    .i_reg_addr      (addr),
    .i_reg_wdata     (wdata),
    .o_reg_rdata     (rdata),
    .i_gpio_in       (gpio_in),
    .o_gpio_out      (gpio_out),
    .o_gpio_oe       (gpio_oe),
    .o_gpio_intr     (gpio_intr),
    .o_gpio_intr_any (intr_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; strobe lands on the next posedge; returns at the following negedge.
  task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; wr = 1'b0; wdata = 8'h00;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [7:0] d);
    sel = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0;
    d = rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int first;
    int nz;
    rst_n = 1'b0; sel = 1'b0; wr = 1'b0; addr = 3'd0; wdata = 8'h00; gpio_in = 8'h00;
    idle(3);
    chk("rst_out", gpio_out, 0);
    chk("rst_oe", gpio_oe, 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    idle(1);

    // All registers read zero after reset.
    for (int a = 0; a < 8; a++) begin
      reg_rd(3'(a), v);
      chk($sformatf("rst_reg%0d", a), v, 0);
    end
    $display("reset register reads done");

    // DR / DDR write and read back.
    reg_wr(3'd0, 8'hA5);
    reg_wr(3'd1, 8'h0F);
    chk("gpio_out", gpio_out, 8'hA5);
    chk("gpio_oe", gpio_oe, 8'h0F);
    reg_rd(3'd0, v);
    chk("rd_dr", v, 8'hA5);
    reg_rd(3'd1, v);
    chk("rd_ddr", v, 8'h0F);
    idle(1);
    chk("rdata_hold", rdata, 8'h0F);
    reg_wr(3'd2, 8'hFF);
    reg_rd(3'd2, v);
    chk("ext_ro", v, 8'h00);
    $display("DR/DDR access done");

    // Sync latency: pad set before edge k; read at k+1 -> 0, at k+2 -> 1.
    gpio_in = 8'h01;
    idle(1);
    reg_rd(3'd2, v);
    chk("sync_k1", v, 8'h00);
    reg_rd(3'd2, v);
    chk("sync_k2", v, 8'h01);
    gpio_in = 8'h00;
    idle(5);
    $display("sync latency done");

    // Rising-edge interrupt on bit0.
    reg_wr(3'd4, 8'h01);
    reg_wr(3'd5, 8'h01);
    reg_wr(3'd3, 8'h01);
    gpio_in = 8'h01;
    idle(3);
    chk("edge_k2_any", intr_any, 1'b0);
    idle(1);
    chk("edge_k3_any", intr_any, 1'b1);
    chk("edge_k3_intr", gpio_intr, 8'h01);
    idle(1);
    reg_wr(3'd6, 8'h01);
    reg_rd(3'd6, v);
    chk("w1c_clear", v, 8'h00);
    chk("w1c_any", intr_any, 1'b0);
    gpio_in = 8'h00;
    idle(6);
    reg_rd(3'd6, v);
    chk("fall_noset", v, 8'h00);
    $display("edge interrupt done");

    // Level interrupt on bit1 (high), W1C while held.
    reg_wr(3'd3, 8'h00);
    reg_wr(3'd4, 8'h00);
    reg_wr(3'd5, 8'h02);
    gpio_in = 8'h02;
    idle(4);
    reg_wr(3'd3, 8'h02);
    idle(2);
    reg_rd(3'd6, v);
    chk("lvl_set", v, 8'h02);
    reg_wr(3'd6, 8'h02);
    reg_rd(3'd6, v);
    chk("lvl_reset", v, 8'h02);
    chk("lvl_intr", gpio_intr, 8'h02);
    $display("level interrupt done");

    // Edge event coincident with W1C on bit0.
    reg_wr(3'd3, 8'h00);
    gpio_in = 8'h00;
    idle(4);
    reg_wr(3'd6, 8'hFF);
    reg_rd(3'd6, v);
    chk("clr_all", v, 8'h00);
    reg_wr(3'd4, 8'h01);
    reg_wr(3'd5, 8'h01);
    reg_wr(3'd3, 8'h01);
    gpio_in = 8'h01;
    idle(3);
    reg_wr(3'd6, 8'h01);
    reg_rd(3'd6, v);
    chk("collide_set", v, 8'h01);
    reg_wr(3'd3, 8'h00);
    chk("mask_intr", gpio_intr, 8'h00);
    reg_rd(3'd6, v);
    chk("mask_keep", v, 8'h01);
    gpio_in = 8'h00;
    reg_wr(3'd6, 8'hFF);
    idle(4);
    $display("collision/mask done");

    // Debounce: 10-cycle glitch on bit2 never reaches EXT.
    reg_wr(3'd7, 8'hFF);
    nz = 0;
    gpio_in = 8'h04;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) gpio_in = 8'h00;
      reg_rd(3'd2, v);
      if (v != 8'h00) nz++;
    end
    chk("db_glitch", nz, 0);
    idle(20);

    // Steady high: EXT rises on the third tick after sync2 rises.
    first = -1;
    gpio_in = 8'h04;
    for (int i = 0; i < 60 && first < 0; i++) begin
      reg_rd(3'd2, v);
      if (v[2]) first = i;
    end
    chk("db_seen", first >= 0, 1'b1);
    chk("db_not_early", first >= 34, 1'b1);
    chk("db_not_late", first <= 49, 1'b1);
    chk("db_value", v, 8'h04);
    gpio_in = 8'h00;
    idle(3);
    reg_rd(3'd2, v);
    chk("db_hold", v, 8'h04);
    reg_wr(3'd7, 8'h00);
    reg_rd(3'd2, v);
    chk("db_off_follow", v, 8'h00);
    $display("debounce done first=%0d", first);

    // Async reset mid-cycle with pending interrupts.
    reg_wr(3'd0, 8'hFF);
    reg_wr(3'd4, 8'h00);
    reg_wr(3'd5, 8'h00);
    reg_wr(3'd3, 8'h03);
    idle(2);
    reg_rd(3'd6, v);
    chk("pre_rst_stat", v, 8'h03);
    chk("pre_rst_intr", gpio_intr, 8'h03);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", gpio_out, 0);
    chk("arst_oe", gpio_oe, 0);
    chk("arst_intr", gpio_intr, 0);
    chk("arst_any", intr_any, 0);
    chk("arst_rdata", rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    reg_rd(3'd6, v);
    chk("post_rst_stat", v, 8'h00);
    reg_rd(3'd0, v);
    chk("post_rst_dr", v, 8'h00);
    $display("async reset done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
